// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int unsigned DEF_TX_TIMEOUT   = 4096;
    localparam int unsigned DEF_HOLD_TIMEOUT = 256;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the UART transmit arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
);
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ack;
    logic           grant_valid;
    logic [ID_W-1:0] grant_id;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;
    logic           tx_done;
    logic           err_timeout;
    logic           pkt_abort;

    modport master (
        input  req, req_data, req_last, tx_busy, tx_done,
        output req_ack, grant_valid, grant_id, tx_start, tx_data, err_timeout, pkt_abort
    );

    modport slave (
        output req, req_data, req_last, tx_busy, tx_done,
        input  req_ack, grant_valid, grant_id, tx_start, tx_data, err_timeout, pkt_abort
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin select: first set request after last_grant, with wrap.
module rr_picker #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_grant,
    output logic [ID_W-1:0] winner,
    output logic            found
);
    logic [ID_W-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = ID_W'((32'(last_grant) + k) % N);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N requesters, one whole packet per grant,
// with watchdogs for a stalled transmitter and an abandoned packet.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N            = 4,
    parameter int unsigned ID_W         = 2,
    parameter int unsigned TX_TIMEOUT   = DEF_TX_TIMEOUT,
    parameter int unsigned HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int unsigned TW = $clog2(max_u(TX_TIMEOUT, HOLD_TIMEOUT));
    localparam logic [TW-1:0] TX_LAST   = TW'(TX_TIMEOUT - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            grant_valid_q, grant_valid_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic            last_q, last_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic [7:0]      req_bytes [N];
    logic [7:0]      owner_data;
    logic            owner_req, owner_last;
    logic [ID_W-1:0] pick_id;
    logic            pick_found;
    logic            load_fire, tx_expire, hold_expire, release_grant;
    logic [TW-1:0]   timer_inc;

    for (genvar g = 0; g < N; g++) begin : g_bytes
        assign req_bytes[g] = bus.req_data[8*g +: 8];
    end

    rr_picker #(.N(N), .ID_W(ID_W)) u_picker (
        .req        (bus.req),
        .last_grant (last_grant_q),
        .winner     (pick_id),
        .found      (pick_found)
    );

    always_comb begin
        owner_req   = bus.req[grant_id_q];
        owner_last  = bus.req_last[grant_id_q];
        owner_data  = req_bytes[grant_id_q];
        load_fire   = (state_q == LOAD) && !bus.tx_busy && owner_req;
        // tx_done in the final cycle beats the timeout.
        tx_expire   = (state_q == WAIT) && !bus.tx_done && (timer_q == TX_LAST);
        hold_expire = (state_q == HOLD) && !owner_req && (timer_q == HOLD_LAST);
        timer_inc   = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            last_grant_q  <= ID_W'(N - 1);
            last_q        <= 1'b0;
            tx_data_q     <= '0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
            last_q        <= last_d;
            tx_data_q     <= tx_data_d;
            timer_q       <= timer_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        last_d        = last_q;
        tx_data_d     = tx_data_q;
        timer_d       = timer_q;
        release_grant = 1'b0;
        unique case (state_q)
            IDLE: if (pick_found) begin
                grant_id_d    = pick_id;
                grant_valid_d = 1'b1;
                state_d       = LOAD;
            end
            LOAD: if (load_fire) begin
                tx_data_d = owner_data;
                last_d    = owner_last;
                timer_d   = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                timer_d = timer_inc;
                if (bus.tx_done) begin
                    if (last_q) begin
                        release_grant = 1'b1;
                    end else begin
                        state_d = HOLD;
                        timer_d = '0;
                    end
                end else if (tx_expire) begin
                    release_grant = 1'b1;
                end
            end
            HOLD: begin
                timer_d = timer_inc;
                if (owner_req) state_d = LOAD;
                else if (hold_expire) release_grant = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (release_grant) begin
            state_d       = IDLE;
            grant_valid_d = 1'b0;
            grant_id_d    = '0;
            last_grant_d  = grant_id_q;
            timer_d       = '0;
        end
    end

    // The accepted byte bypasses tx_data_q so it is already valid alongside tx_start.
    always_comb begin
        bus.tx_start    = load_fire;
        bus.req_ack     = '0;
        if (load_fire) bus.req_ack[grant_id_q] = 1'b1;
        bus.tx_data     = load_fire ? owner_data : tx_data_q;
        bus.grant_valid = grant_valid_q;
        bus.grant_id    = grant_id_q;
        bus.err_timeout = tx_expire;
        bus.pkt_abort   = hold_expire;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small queued requester model.
module tb_uart_tx_arbiter;
    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N(N), .ID_W(2)) bus ();

    uart_tx_arbiter #(
        .N(N), .ID_W(2), .TX_TIMEOUT(16), .HOLD_TIMEOUT(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle phases: +1 requester pops, +2 bench drives, +3 requester refresh, +4 sample.
    task cyc();
        @(posedge clk);
        #2;
    endtask

    task smp();
        #2;
    endtask

    logic [8:0]  fifo [N][8];
    int unsigned head [N] = '{default: 0};
    int unsigned tail [N] = '{default: 0};
    logic [N-1:0] ack_seen = '0;

    task automatic push(input int unsigned i, input logic [7:0] d, input logic last);
        fifo[i][tail[i] % 8] = {last, d};
        tail[i]++;
    endtask

    function automatic void refresh();
        logic [N-1:0]   r;
        logic [N-1:0]   l;
        logic [8*N-1:0] dd;
        logic [8:0]     e;
        r = '0; l = '0; dd = '0;
        for (int i = 0; i < N; i++) begin
            if (head[i] != tail[i]) begin
                e = fifo[i][head[i] % 8];
                r[i] = 1'b1;
                l[i] = e[8];
                dd[8*i +: 8] = e[7:0];
            end
        end
        bus.req      = r;
        bus.req_last = l;
        bus.req_data = dd;
    endfunction

    initial begin
        refresh();
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (ack_seen[i] && head[i] != tail[i]) head[i]++;
            refresh();
            #2;
            refresh();
            #1;
            ack_seen = bus.req_ack;
        end
    end

    task automatic wait_start(output int unsigned n);
        n = 0;
        do begin
            cyc();
            bus.tx_done = 1'b0;
            smp();
            n++;
        end while (!bus.tx_start && n < 40);
    endtask

    task automatic check_start(input string tag, input int unsigned id, input logic [7:0] d);
        chk({tag, "_start"}, 32'(bus.tx_start), 1);
        chk({tag, "_id"},    32'(bus.grant_id), id);
        chk({tag, "_data"},  32'(bus.tx_data), 32'(d));
        chk({tag, "_ack"},   32'(bus.req_ack), 32'(1) << id);
    endtask

    task automatic finish_byte(input string tag, input logic [7:0] d, input int unsigned dly);
        logic err_seen;
        err_seen = 1'b0;
        for (int unsigned k = 1; k <= dly; k++) begin
            cyc();
            bus.tx_done = (k == dly);
            smp();
            err_seen |= bus.err_timeout;
        end
        chk({tag, "_hold_data"}, 32'(bus.tx_data), 32'(d));
        chk({tag, "_noerr"}, 32'(err_seen), 0);
    endtask

    task automatic serve(input string tag, input int unsigned id, input logic [7:0] d,
                         input int unsigned exp_gap, input int unsigned dly);
        int unsigned n;
        wait_start(n);
        chk({tag, "_gap"}, n, exp_gap);
        check_start(tag, id, d);
        finish_byte(tag, d, dly);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk(tag, 32'({bus.grant_valid, bus.grant_id, bus.tx_start, bus.req_ack,
                      bus.err_timeout, bus.pkt_abort, bus.tx_data}), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned k;
        logic flag;

        rst = 1'b1;
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        cyc(); smp();
        chk_idle_outs("rst_outs");
        cyc(); rst = 1'b0; smp();

        // single packet
        cyc(); push(0, 8'h55, 1'b1); smp();
        chk("t1_idle_gv", 32'(bus.grant_valid), 0);
        serve("t1", 0, 8'h55, 1, 3);
        cyc(); bus.tx_done = 1'b0; smp();
        chk("t1_release_gv", 32'(bus.grant_valid), 0);
        chk("t1_data_kept", 32'(bus.tx_data), 'h55);

        // round-robin from a fresh pointer
        cyc(); rst = 1'b1; smp();
        cyc(); rst = 1'b0; smp();
        cyc(); push(0, 8'h10, 1'b1); push(1, 8'h11, 1'b1);
        push(3, 8'h13, 1'b1); push(0, 8'h20, 1'b1); smp();
        serve("t2a", 0, 8'h10, 1, 2);
        serve("t2b", 1, 8'h11, 2, 2);
        serve("t2c", 3, 8'h13, 2, 2);
        serve("t2d", 0, 8'h20, 2, 2);

        // multi-byte lock while requester 1 waits
        cyc(); push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1); smp();
        cyc(); bus.tx_done = 1'b0; push(1, 8'hB1, 1'b1); smp();
        check_start("t3a", 2, 8'hA1);
        finish_byte("t3a", 8'hA1, 3);
        serve("t3b", 2, 8'hA2, 2, 1);
        serve("t3c", 2, 8'hA3, 2, 2);
        serve("t3d", 1, 8'hB1, 2, 1);

        // transmitter timeout
        cyc(); push(3, 8'h33, 1'b1); push(0, 8'h30, 1'b1); smp();
        serve("t4a", 3, 8'h33, 1, 0);
        k = 0;
        do begin cyc(); smp(); k++; end while (!bus.err_timeout && k < 40);
        chk("t4_err_cycle", k, 16);
        serve("t4b", 0, 8'h30, 2, 1);
        cyc(); push(2, 8'h42, 1'b1); smp();
        serve("t4c", 2, 8'h42, 1, 16);
        cyc(); bus.tx_done = 1'b0; smp();
        chk("t4c_release_gv", 32'(bus.grant_valid), 0);

        // hold watchdog
        cyc(); push(1, 8'h51, 1'b0); smp();
        serve("t5a", 1, 8'h51, 1, 2);
        k = 0;
        flag = 1'b0;
        do begin
            cyc();
            bus.tx_done = 1'b0;
            if (k == 0) begin push(0, 8'h50, 1'b1); push(2, 8'h52, 1'b1); end
            smp();
            k++;
            flag |= bus.tx_start;
        end while (!bus.pkt_abort && k < 30);
        chk("t5_abort_cycle", k, 8);
        chk("t5_hold_no_start", 32'(flag), 0);
        chk("t5_abort_gv", 32'(bus.grant_valid), 1);
        cyc(); push(1, 8'h61, 1'b1); smp();
        chk("t5_release_gv", 32'(bus.grant_valid), 0);
        serve("t5b", 2, 8'h52, 1, 1);
        serve("t5c", 0, 8'h50, 2, 1);
        serve("t5d", 1, 8'h61, 2, 1);

        // busy transmitter, then reset during WAIT
        cyc(); bus.tx_done = 1'b0; bus.tx_busy = 1'b1; push(3, 8'h77, 1'b1); smp();
        flag = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            cyc(); smp();
            flag |= bus.tx_start;
        end
        chk("t6_busy_no_start", 32'(flag), 0);
        chk("t6_busy_owner", 32'({bus.grant_valid, bus.grant_id}), 'b111);
        cyc(); bus.tx_busy = 1'b0; smp();
        check_start("t6a", 3, 8'h77);
        cyc(); push(0, 8'h80, 1'b1); push(2, 8'h82, 1'b1); smp();
        cyc(); rst = 1'b1; smp();
        chk_idle_outs("t6_rst_outs");
        cyc(); smp();
        chk_idle_outs("t6_rst_hold_outs");
        cyc(); rst = 1'b0; smp();
        serve("t6b", 0, 8'h80, 1, 1);
        serve("t6c", 2, 8'h82, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
